// File: rtl/u_sequencer_if.sv
// Sequencer bus: control-word sequencing fields, status inputs and registered
// micro-address outputs. The master drives the control word; the sequencer is the slave.
interface u_sequencer_if #(
    parameter int unsigned OPC_W   = 8,
    parameter int unsigned UADDR_W = 15
);
    logic               stall;
    logic [1:0]         typ;
    logic [6:0]         offset;
    logic               cond_invert;
    logic               cond_flag_src;
    logic [3:0]         cond_sel;
    logic               escape;
    logic [3:0]         alu_flags;
    logic [3:0]         u_flags;
    logic [7:0]         cpu_status;
    logic [OPC_W-1:0]   ir;
    logic               int_pending;
    logic               dma_req;
    logic [UADDR_W-1:0] u_addr;
    logic               halted;
    logic               irq_taken;
    logic               ustep_ovf;

    modport master (
        output stall, typ, offset, cond_invert, cond_flag_src, cond_sel, escape,
               alu_flags, u_flags, cpu_status, ir, int_pending, dma_req,
        input  u_addr, halted, irq_taken, ustep_ovf
    );

    modport slave (
        input  stall, typ, offset, cond_invert, cond_flag_src, cond_sel, escape,
               alu_flags, u_flags, cpu_status, ir, int_pending, dma_req,
        output u_addr, halted, irq_taken, ustep_ovf
    );
endinterface

// File: rtl/u_sequencer.sv
// Microcode sequencer: evaluates the control word's sequencing fields each cycle and
// registers the next micro-address {esc, opc, step}. Handles IRQ entry, HALT and stall.
module u_sequencer #(
    parameter int unsigned           OPC_W       = 8,
    parameter int unsigned           STEP_W      = 6,
    parameter int unsigned           UADDR_W     = 15,
    parameter logic [UADDR_W-1:0]    RESET_UADDR = 15'h0010,
    parameter logic [UADDR_W-1:0]    FETCH_UADDR = 15'h0000,
    parameter logic [UADDR_W-1:0]    IRQ_UADDR   = 15'h3FC0
) (
    input logic          clk,
    input logic          rst,
    u_sequencer_if.slave bus
);
    localparam logic [1:0] TypSeq      = 2'b00;
    localparam logic [1:0] TypBranch   = 2'b01;
    localparam logic [1:0] TypFetch    = 2'b10;
    localparam logic [1:0] TypDispatch = 2'b11;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    state_e               r_state, w_state_d;
    logic [UADDR_W-1:0]   r_uaddr, w_uaddr_d;
    logic                 r_irq_taken, w_irq_taken_d;
    logic                 r_ustep_ovf, w_ustep_ovf_d;

    logic [STEP_W-1:0]         w_step, w_step_inc, w_step_br;
    logic [UADDR_W-STEP_W-1:0] w_page;
    logic [UADDR_W-1:0]        w_seq_uaddr;
    logic                      w_step_wrap;
    logic [3:0]                w_flags;
    logic                      w_zf, w_cf, w_sf, w_of;
    logic                      w_irq_en, w_mode, w_paging_en, w_halt_req, w_dir, w_dma_ack;
    logic                      w_cond_raw, w_cond, w_irq_ok;
    logic                      w_unused;

    assign w_step      = r_uaddr[STEP_W-1:0];
    assign w_page      = r_uaddr[UADDR_W-1:STEP_W];
    assign w_step_inc  = w_step + STEP_W'(1);
    assign w_step_wrap = &w_step;
    assign w_seq_uaddr = {w_page, w_step_inc};
    // Adding the low STEP_W bits of the offset equals adding sext(offset) mod 64.
    assign w_step_br   = w_step + bus.offset[STEP_W-1:0];

    assign w_flags     = bus.cond_flag_src ? bus.u_flags : bus.alu_flags;
    assign w_zf        = w_flags[0];
    assign w_cf        = w_flags[1];
    assign w_sf        = w_flags[2];
    assign w_of        = w_flags[3];

    assign w_dma_ack   = bus.cpu_status[0];
    assign w_irq_en    = bus.cpu_status[1];
    assign w_mode      = bus.cpu_status[2];
    assign w_paging_en = bus.cpu_status[3];
    assign w_halt_req  = bus.cpu_status[4];
    assign w_dir       = bus.cpu_status[7];
    assign w_unused    = ^{bus.cpu_status[6:5], bus.offset[6]};

    // Blocking a second consecutive IRQ load keeps irq_taken a single-cycle pulse.
    assign w_irq_ok    = bus.int_pending & w_irq_en & ~r_irq_taken;

    // Condition multiplexer
    always_comb begin
        w_cond_raw = 1'b0;
        case (bus.cond_sel)
            4'd0:    w_cond_raw = w_zf;
            4'd1:    w_cond_raw = w_cf;
            4'd2:    w_cond_raw = w_sf;
            4'd3:    w_cond_raw = w_of;
            4'd4:    w_cond_raw = w_zf | w_cf;
            4'd5:    w_cond_raw = w_sf ^ w_of;
            4'd6:    w_cond_raw = (w_sf ^ w_of) | w_zf;
            4'd7:    w_cond_raw = bus.dma_req;
            4'd8:    w_cond_raw = w_irq_en;
            4'd9:    w_cond_raw = w_mode;
            4'd10:   w_cond_raw = w_paging_en;
            4'd11:   w_cond_raw = w_dir;
            4'd12:   w_cond_raw = bus.int_pending;
            4'd13:   w_cond_raw = w_dma_ack;
            4'd14:   w_cond_raw = 1'b1;
            default: w_cond_raw = 1'b0;
        endcase
    end

    assign w_cond = w_cond_raw ^ bus.cond_invert;

    // Next-state, next micro-address and pulse/sticky flag logic
    always_comb begin
        w_state_d     = r_state;
        w_uaddr_d     = r_uaddr;
        w_irq_taken_d = 1'b0;
        w_ustep_ovf_d = r_ustep_ovf;
        if (!bus.stall) begin
            case (r_state)
                StHalt: begin
                    w_uaddr_d = FETCH_UADDR;
                    if (w_irq_ok) begin
                        w_uaddr_d     = IRQ_UADDR;
                        w_irq_taken_d = 1'b1;
                        w_state_d     = StRun;
                    end
                end
                default: begin
                    unique case (bus.typ)
                        TypSeq: begin
                            w_uaddr_d     = w_seq_uaddr;
                            w_ustep_ovf_d = r_ustep_ovf | w_step_wrap;
                        end
                        TypBranch: begin
                            if (w_cond) begin
                                w_uaddr_d = {w_page, w_step_br};
                            end else begin
                                w_uaddr_d     = w_seq_uaddr;
                                w_ustep_ovf_d = r_ustep_ovf | w_step_wrap;
                            end
                        end
                        TypFetch: begin
                            if (w_irq_ok) begin
                                w_uaddr_d     = IRQ_UADDR;
                                w_irq_taken_d = 1'b1;
                            end else if (w_halt_req) begin
                                w_uaddr_d = FETCH_UADDR;
                                w_state_d = StHalt;
                            end else begin
                                w_uaddr_d = FETCH_UADDR;
                            end
                        end
                        TypDispatch: begin
                            w_uaddr_d = {bus.escape, bus.ir, {STEP_W{1'b0}}};
                        end
                    endcase
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StRun;
            r_uaddr     <= RESET_UADDR;
            r_irq_taken <= 1'b0;
            r_ustep_ovf <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_uaddr     <= w_uaddr_d;
            r_irq_taken <= w_irq_taken_d;
            r_ustep_ovf <= w_ustep_ovf_d;
        end
    end

    assign bus.u_addr    = r_uaddr;
    assign bus.halted    = (r_state == StHalt);
    assign bus.irq_taken = r_irq_taken;
    assign bus.ustep_ovf = r_ustep_ovf;
endmodule

// File: tb/tb_u_sequencer.sv
// Bench for u_sequencer: condition table, hand-written corner sequences and a random run
// checked against an address-arithmetic reference model.
module tb_u_sequencer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    u_sequencer_if #(.OPC_W(8), .UADDR_W(15)) bus ();

    u_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_addr;
    bit m_halted;
    bit m_ovf;
    bit m_irq;

    typedef struct {
        int       sel;
        bit       src;
        bit       inv;
        bit [3:0] alu;
        bit [3:0] uf;
        bit [7:0] st;
        bit       intp;
        bit       dma;
        bit       taken;
    } cond_vec_t;

    cond_vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_cond();
        bit [3:0] f;
        bit       zf, cf, sf, of, c;
        bit [7:0] st;
        f  = bus.cond_flag_src ? bus.u_flags : bus.alu_flags;
        zf = f[0]; cf = f[1]; sf = f[2]; of = f[3];
        st = bus.cpu_status;
        case (int'(bus.cond_sel))
            0:  c = zf;
            1:  c = cf;
            2:  c = sf;
            3:  c = of;
            4:  c = zf | cf;
            5:  c = sf ^ of;
            6:  c = (sf ^ of) | zf;
            7:  c = bus.dma_req;
            8:  c = st[1];
            9:  c = st[2];
            10: c = st[3];
            11: c = st[7];
            12: c = bus.int_pending;
            13: c = st[0];
            14: c = 1'b1;
            default: c = 1'b0;
        endcase
        return c ^ bus.cond_invert;
    endfunction

    task automatic model_seq();
        int step, page;
        step = m_addr % 64;
        page = m_addr / 64;
        if (step == 63) m_ovf = 1'b1;
        m_addr = page * 64 + (step + 1) % 64;
    endtask

    task automatic model_step();
        bit irq_ok, nirq;
        int off, step, page;
        if (rst) begin
            m_addr = 'h10; m_halted = 0; m_ovf = 0; m_irq = 0;
        end else if (bus.stall) begin
            m_irq = 0;
        end else begin
            irq_ok = bus.int_pending && bus.cpu_status[1] && !m_irq;
            nirq   = 0;
            if (m_halted) begin
                m_addr = 0;
                if (irq_ok) begin
                    m_addr = 'h3FC0; m_halted = 0; nirq = 1;
                end
            end else begin
                case (int'(bus.typ))
                    0: model_seq();
                    1: begin
                        if (model_cond()) begin
                            off  = int'(bus.offset);
                            if (off >= 64) off -= 128;
                            step = m_addr % 64;
                            page = m_addr / 64;
                            m_addr = page * 64 + (((step + off) % 64) + 64) % 64;
                        end else begin
                            model_seq();
                        end
                    end
                    2: begin
                        if (irq_ok) begin
                            m_addr = 'h3FC0; nirq = 1;
                        end else begin
                            m_addr = 0;
                            if (bus.cpu_status[4]) m_halted = 1;
                        end
                    end
                    default: m_addr = int'(bus.escape) * 16384 + int'(bus.ir) * 64;
                endcase
            end
            m_irq = nirq;
        end
    endtask

    // Advance one clock and compare every output with the model
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, "/u_addr"}, 32'(bus.u_addr), 32'(m_addr));
        check({tag, "/halted"}, 32'(bus.halted), 32'(m_halted));
        check({tag, "/irq_taken"}, 32'(bus.irq_taken), 32'(m_irq));
        check({tag, "/ustep_ovf"}, 32'(bus.ustep_ovf), 32'(m_ovf));
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.typ = 0; bus.offset = 0; bus.cond_invert = 0;
        bus.cond_flag_src = 0; bus.cond_sel = 0; bus.escape = 0; bus.alu_flags = 0;
        bus.u_flags = 0; bus.cpu_status = 0; bus.ir = 0; bus.int_pending = 0;
        bus.dma_req = 0;
    endtask

    // Dispatch to page 0x3A (0x0E80) then step forward n times
    task automatic goto_e80(input int n);
        bus.typ = 2'b11; bus.ir = 8'h3A; bus.escape = 0;
        tick("goto_disp");
        bus.typ = 2'b00;
        for (int i = 0; i < n; i++) tick("goto_seq");
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        clear_inputs();

        vecs.push_back('{0,  0, 0, 4'b0001, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{0,  1, 0, 4'b0001, 4'b0000, 8'h00, 0, 0, 0});
        vecs.push_back('{1,  0, 0, 4'b0010, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{2,  1, 0, 4'b0000, 4'b0100, 8'h00, 0, 0, 1});
        vecs.push_back('{3,  0, 0, 4'b1000, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{4,  0, 0, 4'b0010, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{4,  0, 0, 4'b1100, 4'b0000, 8'h00, 0, 0, 0});
        vecs.push_back('{5,  0, 0, 4'b0100, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{5,  0, 0, 4'b1100, 4'b0000, 8'h00, 0, 0, 0});
        vecs.push_back('{6,  0, 0, 4'b1101, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{6,  0, 0, 4'b1100, 4'b0000, 8'h00, 0, 0, 0});
        vecs.push_back('{7,  0, 0, 4'b0000, 4'b0000, 8'h00, 0, 1, 1});
        vecs.push_back('{8,  0, 0, 4'b0000, 4'b0000, 8'h02, 0, 0, 1});
        vecs.push_back('{9,  0, 0, 4'b0000, 4'b0000, 8'h04, 0, 0, 1});
        vecs.push_back('{10, 0, 0, 4'b0000, 4'b0000, 8'h08, 0, 0, 1});
        vecs.push_back('{11, 0, 0, 4'b0000, 4'b0000, 8'h80, 0, 0, 1});
        vecs.push_back('{11, 0, 0, 4'b0000, 4'b0000, 8'h7F, 0, 0, 0});
        vecs.push_back('{12, 0, 0, 4'b0000, 4'b0000, 8'h00, 1, 0, 1});
        vecs.push_back('{13, 0, 0, 4'b0000, 4'b0000, 8'h01, 0, 0, 1});
        vecs.push_back('{14, 0, 0, 4'b0000, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{15, 0, 0, 4'b0000, 4'b0000, 8'h00, 0, 0, 0});
        vecs.push_back('{15, 0, 1, 4'b0000, 4'b0000, 8'h00, 0, 0, 1});
        vecs.push_back('{14, 0, 1, 4'b0000, 4'b0000, 8'h00, 0, 0, 0});

        // Reset held with stall asserted
        rst = 1; bus.stall = 1;
        tick("rst1");
        check("rst_uaddr", 32'(bus.u_addr), 32'h0010);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_ovf", 32'(bus.ustep_ovf), 32'h0);
        tick("rst2");
        rst = 0; bus.stall = 0;

        // Dispatch with and without escape
        bus.typ = 2'b11; bus.ir = 8'h3A; bus.escape = 0;
        tick("disp0");
        check("disp_esc0", 32'(bus.u_addr), 32'h0E80);
        bus.escape = 1;
        tick("disp1");
        check("disp_esc1", 32'(bus.u_addr), 32'h4E80);

        // Backward branch on zf
        bus.cond_sel = 0; bus.cond_flag_src = 0; bus.offset = 7'h7C;
        goto_e80(5);
        bus.typ = 2'b01; bus.alu_flags = 4'b0001;
        tick("br_zf1");
        check("br_taken", 32'(bus.u_addr), 32'h0E81);
        goto_e80(5);
        bus.typ = 2'b01; bus.alu_flags = 4'b0000;
        tick("br_zf0");
        check("br_not_taken", 32'(bus.u_addr), 32'h0E86);
        goto_e80(5);
        bus.typ = 2'b01; bus.alu_flags = 4'b0001; bus.cond_invert = 1;
        tick("br_inv");
        check("br_inverted", 32'(bus.u_addr), 32'h0E86);
        clear_inputs();

        // Condition table: forward branch +5 from 0x0E80
        foreach (vecs[i]) begin
            clear_inputs();
            goto_e80(0);
            bus.typ = 2'b01; bus.offset = 7'd5;
            bus.cond_sel = 4'(vecs[i].sel); bus.cond_flag_src = vecs[i].src;
            bus.cond_invert = vecs[i].inv; bus.alu_flags = vecs[i].alu;
            bus.u_flags = vecs[i].uf; bus.cpu_status = vecs[i].st;
            bus.int_pending = vecs[i].intp; bus.dma_req = vecs[i].dma;
            tick("cond_vec");
            check($sformatf("cond_sel%0d_v%0d", vecs[i].sel, i), 32'(bus.u_addr),
                  vecs[i].taken ? 32'h0E85 : 32'h0E81);
        end
        clear_inputs();

        // Step wrap sets sticky ovf
        goto_e80(63);
        check("pre_wrap_addr", 32'(bus.u_addr), 32'h0EBF);
        check("pre_wrap_ovf", 32'(bus.ustep_ovf), 32'h0);
        tick("wrap");
        check("wrap_addr", 32'(bus.u_addr), 32'h0E80);
        check("wrap_ovf", 32'(bus.ustep_ovf), 32'h1);
        for (int i = 0; i < 5; i++) tick("post_wrap");
        check("ovf_sticky", 32'(bus.ustep_ovf), 32'h1);
        rst = 1;
        tick("ovf_rst");
        rst = 0;
        check("ovf_cleared", 32'(bus.ustep_ovf), 32'h0);

        // HALT entry, control word ignored, IRQ exit
        bus.typ = 2'b10; bus.cpu_status = 8'h10;
        tick("halt_enter");
        for (int i = 0; i < 10; i++) begin
            bus.typ = 2'(i); bus.ir = 8'h55;
            tick("halt_hold");
            check("halt_halted", 32'(bus.halted), 32'h1);
            check("halt_uaddr", 32'(bus.u_addr), 32'h0000);
        end
        bus.int_pending = 1; bus.cpu_status = 8'h12;
        tick("halt_exit");
        check("halt_exit_uaddr", 32'(bus.u_addr), 32'h3FC0);
        check("halt_exit_irq", 32'(bus.irq_taken), 32'h1);
        check("halt_exit_halted", 32'(bus.halted), 32'h0);
        bus.typ = 2'b00;
        tick("irq_pulse_end");
        check("irq_one_cycle", 32'(bus.irq_taken), 32'h0);
        clear_inputs();

        // IRQ wins over halt at fetch
        bus.typ = 2'b10; bus.cpu_status = 8'h12; bus.int_pending = 1;
        tick("irq_wins");
        check("irq_wins_uaddr", 32'(bus.u_addr), 32'h3FC0);
        check("irq_wins_halted", 32'(bus.halted), 32'h0);
        check("irq_wins_pulse", 32'(bus.irq_taken), 32'h1);
        clear_inputs();
        bus.typ = 2'b11;
        tick("irq_wins_after");
        check("irq_wins_still_run", 32'(bus.halted), 32'h0);

        // Stall mid-branch, then reset during stall
        goto_e80(5);
        bus.typ = 2'b01; bus.cond_sel = 4'd14; bus.offset = 7'd3; bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall_hold", 32'(bus.u_addr), 32'h0E85);
        end
        rst = 1;
        tick("stall_rst");
        check("stall_rst_uaddr", 32'(bus.u_addr), 32'h0010);
        rst = 0;
        clear_inputs();

        // Random run against the model
        for (int i = 0; i < 3000; i++) begin
            rst               = ($urandom_range(0, 99) == 0);
            bus.stall         = ($urandom_range(0, 7) == 0);
            bus.typ           = 2'($urandom);
            bus.offset        = 7'($urandom);
            bus.cond_invert   = 1'($urandom);
            bus.cond_flag_src = 1'($urandom);
            bus.cond_sel      = 4'($urandom);
            bus.escape        = 1'($urandom);
            bus.alu_flags     = 4'($urandom);
            bus.u_flags       = 4'($urandom);
            bus.cpu_status    = 8'($urandom) & 8'hEF;
            if ($urandom_range(0, 7) == 0) bus.cpu_status[4] = 1'b1;
            bus.ir            = 8'($urandom);
            bus.int_pending   = 1'($urandom);
            bus.dma_req       = 1'($urandom);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
